// File: rtl/adc_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// adc_cmd_arbiter
//
// Shares one ADC command/response port between two requesters.
//
// Command side: while idle, any requester presenting a start-of-packet beat
// may win the port. The winner is registered into OWNER and keeps the port
// for the whole packet (until its EOP beat is accepted). While locked, the
// owner's command fields pass straight through to the ADC port.
//
// Response side: every accepted command beat pushes the owner index into a
// small tag FIFO. Each ADC response pops the head tag and is steered to that
// requester in the same cycle. A response that arrives with no outstanding
// tag is dropped and latches the sticky ERR_ORPHAN flag.
//
// Configuration:
//   ADC_ARB_ROUND_ROBIN_EN  defined   -> on a tie the requester that was not
//                                        granted last wins.
//                           undefined -> on a tie requester 0 always wins.
//
// Parameters:
//   TAG_DEPTH      depth of the response-routing tag FIFO (power of 2, 2..16)
//
// Ports:
//   CLK            clock, rising edge
//   RESETn         synchronous active-low reset
//   REQ_C_*        per-requester command inputs (Channel: 5 bits each),
//                  REQ_C_Ready per-requester command ready
//   ADC_C_*        shared ADC command port, ADC_C_Ready from the ADC
//   ADC_R_*        ADC response inputs
//   REQ_R_Valid    per-requester response valid
//   REQ_R_*        response fields broadcast to both requesters
//   BUSY           packet lock held
//   OWNER          index of the current (or last) owner
//   ERR_ORPHAN     sticky flag: a response arrived with no outstanding tag
// ---------------------------------------------------------------------------
module adc_cmd_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [1:0]  REQ_C_Valid,
  input  logic [9:0]  REQ_C_Channel,
  input  logic [1:0]  REQ_C_SOP,
  input  logic [1:0]  REQ_C_EOP,
  output logic [1:0]  REQ_C_Ready,
  output logic        ADC_C_Valid,
  output logic [4:0]  ADC_C_Channel,
  output logic        ADC_C_SOP,
  output logic        ADC_C_EOP,
  input  logic        ADC_C_Ready,
  input  logic        ADC_R_Valid,
  input  logic [4:0]  ADC_R_Channel,
  input  logic [11:0] ADC_R_Data,
  input  logic        ADC_R_SOP,
  input  logic        ADC_R_EOP,
  output logic [1:0]  REQ_R_Valid,
  output logic [4:0]  REQ_R_Channel,
  output logic [11:0] REQ_R_Data,
  output logic        REQ_R_SOP,
  output logic        REQ_R_EOP,
  output logic        BUSY,
  output logic        OWNER,
  output logic        ERR_ORPHAN
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAG_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [0:0]       state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             err_orphan_reg;

  logic             tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic       is_lock;
  logic       fifo_full, fifo_empty;
  logic       cmd_open;
  logic       push, pop;
  logic       head_tag;
  logic       grant, winner;
  logic [1:0] candidate;
  logic [4:0] req_chan [2];
  logic       own_valid, own_sop, own_eop;
  logic [4:0] own_chan;

  assign is_lock    = (state_reg == ST_LOCK);
  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);

  // The port only opens while locked and a tag slot is free; a pop in the
  // same cycle does not reopen it, so the full check uses the registered count.
  assign cmd_open = is_lock & ~fifo_full;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_chan[gi]    = REQ_C_Channel[5*gi +: 5];
      assign candidate[gi]   = REQ_C_Valid[gi] & REQ_C_SOP[gi];
      assign REQ_C_Ready[gi] = cmd_open & (owner_reg == 1'(gi)) & ADC_C_Ready;
      assign REQ_R_Valid[gi] = pop & (head_tag == 1'(gi));
    end
  endgenerate

  assign own_valid = REQ_C_Valid[owner_reg];
  assign own_sop   = REQ_C_SOP[owner_reg];
  assign own_eop   = REQ_C_EOP[owner_reg];
  assign own_chan  = req_chan[owner_reg];

  assign ADC_C_Valid   = cmd_open & own_valid;
  assign ADC_C_Channel = is_lock ? own_chan : 5'd0;
  assign ADC_C_SOP     = is_lock & own_sop;
  assign ADC_C_EOP     = is_lock & own_eop;

  assign push     = ADC_C_Valid & ADC_C_Ready;
  assign pop      = ADC_R_Valid & ~fifo_empty;
  assign head_tag = tag_mem[rd_ptr_reg];

  // A new packet may only be granted when there is room for its first tag.
  assign grant = ~is_lock & (|candidate) & ~fifo_full;

  // ---------------------------------------------------------------------
  // Tie-break
  // ---------------------------------------------------------------------
`ifdef ADC_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;

  // Single candidate wins outright; on a tie the other side gets its turn.
  assign winner = (candidate == 2'b11) ? ~last_grant_reg : candidate[1];

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      last_grant_reg <= 1'b1;
    end else if (grant) begin
      last_grant_reg <= winner;
    end
  end
`else
  // Requester 0 wins whenever it is a candidate.
  assign winner = ~candidate[0];
`endif

  // ---------------------------------------------------------------------
  // Lock controller
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant) begin
          state_next = ST_LOCK;
          owner_next = winner;
        end
      end
      ST_LOCK: begin
        // Only an accepted EOP releases the lock; a stalled owner keeps it.
        if (push & own_eop) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_reg <= ST_IDLE;
      owner_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  // ---------------------------------------------------------------------
  // Tag FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (push) begin
      tag_mem[wr_ptr_reg] <= owner_reg;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Orphan detection
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      err_orphan_reg <= 1'b0;
    end else if (ADC_R_Valid & fifo_empty) begin
      err_orphan_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign REQ_R_Channel = ADC_R_Channel;
  assign REQ_R_Data    = ADC_R_Data;
  assign REQ_R_SOP     = ADC_R_SOP;
  assign REQ_R_EOP     = ADC_R_EOP;

  assign BUSY       = is_lock;
  assign OWNER      = owner_reg;
  assign ERR_ORPHAN = err_orphan_reg;

endmodule

// File: tb/tb_adc_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adc_cmd_arbiter
//
// Randomised scoreboard bench for adc_cmd_arbiter. A driver feeds packets
// from per-requester queues, a reference model tracks lock/owner/tag-queue
// state from the arbitration rules and pushes expected response routing into
// a scoreboard queue, and a response monitor pops that queue whenever the
// DUT routes a response. Directed phases cover the single-packet flow, tie
// breaking, FIFO-full back-pressure, orphans and mid-packet stall/reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_cmd_arbiter;

  localparam int TAG_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [1:0]  REQ_C_Valid = '0;
  logic [9:0]  REQ_C_Channel = '0;
  logic [1:0]  REQ_C_SOP = '0;
  logic [1:0]  REQ_C_EOP = '0;
  logic [1:0]  REQ_C_Ready;
  logic        ADC_C_Valid;
  logic [4:0]  ADC_C_Channel;
  logic        ADC_C_SOP;
  logic        ADC_C_EOP;
  logic        ADC_C_Ready = 1'b0;
  logic        ADC_R_Valid = 1'b0;
  logic [4:0]  ADC_R_Channel = '0;
  logic [11:0] ADC_R_Data = '0;
  logic        ADC_R_SOP = 1'b0;
  logic        ADC_R_EOP = 1'b0;
  logic [1:0]  REQ_R_Valid;
  logic [4:0]  REQ_R_Channel;
  logic [11:0] REQ_R_Data;
  logic        REQ_R_SOP;
  logic        REQ_R_EOP;
  logic        BUSY;
  logic        OWNER;
  logic        ERR_ORPHAN;

  adc_cmd_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .REQ_C_Valid(REQ_C_Valid), .REQ_C_Channel(REQ_C_Channel),
    .REQ_C_SOP(REQ_C_SOP), .REQ_C_EOP(REQ_C_EOP), .REQ_C_Ready(REQ_C_Ready),
    .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel),
    .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready),
    .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data),
    .ADC_R_SOP(ADC_R_SOP), .ADC_R_EOP(ADC_R_EOP),
    .REQ_R_Valid(REQ_R_Valid), .REQ_R_Channel(REQ_R_Channel), .REQ_R_Data(REQ_R_Data),
    .REQ_R_SOP(REQ_R_SOP), .REQ_R_EOP(REQ_R_EOP),
    .BUSY(BUSY), .OWNER(OWNER), .ERR_ORPHAN(ERR_ORPHAN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0] ch;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t src_q [2][$];       // pending command beats per requester
  int    exp_q [$];          // scoreboard: expected routing of each outstanding command
  int    grant_log [$];      // observed owners at each lock start
  beat_t acc_log [$];        // observed accepted ADC command beats
  int    rsp_cnt [2];
  int    acc_cnt = 0;

  // stimulus knobs
  int p_valid = 100, p_rdy = 100, p_resp = 0;
  int resp_mode = 0;         // 0 off, 1 only when a tag is outstanding, 2 unconditional
  int stall [2];
  bit flush = 1'b0;

  // reference-model state
  bit m_locked = 1'b0;
  bit m_owner  = 1'b1;
  bit m_last   = 1'b1;
  bit err_exp  = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver: one writer for every DUT input except RESETn
  // -------------------------------------------------------------------------
  initial begin : driver
    bit    taken [2];
    beat_t b;
    stall[0] = 0;
    stall[1] = 0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) taken[i] = REQ_C_Valid[i] & REQ_C_Ready[i];
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++)
        if (taken[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (flush) begin
        for (int i = 0; i < 2; i++) begin
          src_q[i].delete();
          stall[i] = 0;
        end
        flush = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (src_q[i].size() > 0) b = src_q[i][0];
        else b = '0;
        REQ_C_Channel[5*i +: 5] = b.ch;
        REQ_C_SOP[i] = b.sop;
        REQ_C_EOP[i] = b.eop;
        REQ_C_Valid[i] = (src_q[i].size() > 0) && (stall[i] == 0) &&
                         ($urandom_range(99) < p_valid);
        if (stall[i] > 0) stall[i]--;
      end
      ADC_C_Ready = ($urandom_range(99) < p_rdy);
      case (resp_mode)
        1:       ADC_R_Valid = (exp_q.size() > 0) && ($urandom_range(99) < p_resp);
        2:       ADC_R_Valid = ($urandom_range(99) < p_resp);
        default: ADC_R_Valid = 1'b0;
      endcase
      ADC_R_Channel = 5'($urandom);
      ADC_R_Data    = 12'($urandom);
      ADC_R_SOP     = 1'($urandom);
      ADC_R_EOP     = 1'($urandom);
    end
  end

  // -------------------------------------------------------------------------
  // Reference model: arbitration rules, command-side expectations, tag pushes
  // -------------------------------------------------------------------------
  initial begin : model
    bit       n_locked, n_owner, n_last, do_push, rst, full, winner, e_valid;
    bit [1:0] cand, e_rdy;
    int       o, push_tag;
    forever begin
      @(negedge CLK);
      full = (exp_q.size() >= TAG_DEPTH);
      n_locked = m_locked; n_owner = m_owner; n_last = m_last;
      do_push = 1'b0; e_valid = 1'b0; e_rdy = 2'b00; push_tag = m_owner;
      o = m_owner;
      chk("BUSY", BUSY, m_locked);
      chk("OWNER", OWNER, m_owner);
      if (!m_locked) begin
        cand = REQ_C_Valid & REQ_C_SOP;
        if (cand != 2'b00 && !full) begin
          if (cand == 2'b11) begin
`ifdef ADC_ARB_ROUND_ROBIN_EN
            winner = ~m_last;
`else
            winner = 1'b0;
`endif
          end else begin
            winner = cand[1];
          end
          n_locked = 1'b1; n_owner = winner; n_last = winner;
          $display("[%0t] grant req%0d", $time, winner);
        end
      end else begin
        chk("ADC_C_Channel", ADC_C_Channel, REQ_C_Channel[5*o +: 5]);
        chk("ADC_C_SOP", ADC_C_SOP, REQ_C_SOP[o]);
        chk("ADC_C_EOP", ADC_C_EOP, REQ_C_EOP[o]);
        if (!full) begin
          e_valid  = REQ_C_Valid[o];
          e_rdy[o] = ADC_C_Ready;
          if (e_valid && ADC_C_Ready) begin
            do_push = 1'b1;
            if (REQ_C_EOP[o]) n_locked = 1'b0;
          end
        end
      end
      chk("ADC_C_Valid", ADC_C_Valid, e_valid);
      chk("REQ_C_Ready", REQ_C_Ready, e_rdy);
      rst = !RESETn;
      @(posedge CLK);
      if (rst) begin
        m_locked = 1'b0; m_owner = 1'b1; m_last = 1'b1;
        exp_q.delete();
      end else begin
        m_locked = n_locked; m_owner = n_owner; m_last = n_last;
        if (do_push) exp_q.push_back(push_tag);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response monitor: pops the scoreboard when the DUT routes a response
  // -------------------------------------------------------------------------
  initial begin : resp_mon
    int t;
    rsp_cnt[0] = 0;
    rsp_cnt[1] = 0;
    forever begin
      @(negedge CLK);
      #1;
      chk("ERR_ORPHAN", ERR_ORPHAN, err_exp);
      chk("REQ_R_Channel", REQ_R_Channel, ADC_R_Channel);
      chk("REQ_R_Data", REQ_R_Data, ADC_R_Data);
      chk("REQ_R_SOP_EOP", {REQ_R_SOP, REQ_R_EOP}, {ADC_R_SOP, ADC_R_EOP});
      if (REQ_R_Valid != 2'b00) begin
        chk("rsp_needs_adc_valid", ADC_R_Valid, 1);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", REQ_R_Valid, 0);
        end else begin
          t = exp_q.pop_front();
          chk("rsp_route", REQ_R_Valid, 2'b01 << t);
          rsp_cnt[t]++;
          $display("[%0t] rsp ch=%0d data=%03h -> req%0d", $time, ADC_R_Channel, ADC_R_Data, t);
        end
      end else if (ADC_R_Valid) begin
        chk("rsp_orphan_expected", exp_q.size(), 0);
        if (exp_q.size() == 0) begin
          err_exp = 1'b1;
          $display("[%0t] orphan rsp ch=%0d dropped", $time, ADC_R_Channel);
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (!RESETn) err_exp = 1'b0;
    end
  end

  // observation of DUT grants and accepted beats for directed checks
  initial begin : grant_mon
    bit busy_prev = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      if (BUSY && !busy_prev) grant_log.push_back(int'(OWNER));
      if (ADC_C_Valid && ADC_C_Ready) begin
        acc_cnt++;
        acc_log.push_back({ADC_C_Channel, ADC_C_SOP, ADC_C_EOP});
      end
      busy_prev = BUSY;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic do_reset(input int cycles);
    @(posedge CLK);
    #2;
    RESETn = 1'b0;
    flush = 1'b1;
    repeat (cycles) @(posedge CLK);
    #2;
    RESETn = 1'b1;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && !m_locked) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_idle_timeout"}, (n >= limit), 0);
  endtask

  task automatic wait_drain(input int limit, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_drain_timeout"}, (n >= limit), 0);
  endtask

  task automatic pulse_resp();
    @(negedge CLK);
    resp_mode = 2; p_resp = 100;
    @(negedge CLK);
    resp_mode = 0;
  endtask

  task automatic add_pkt(input int r, input int len, input int ch0);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.ch  = 5'(ch0 + k);
      b.sop = (k == 0);
      b.eop = (k == len - 1);
      src_q[r].push_back(b);
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence
  // -------------------------------------------------------------------------
  initial begin : main
    int exp_g [4];
    int n;
    beat_t eb;
`ifdef ADC_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    RESETn = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RESETn = 1'b1;
    @(negedge CLK);
    #3;
    chk("rst_BUSY", BUSY, 0);
    chk("rst_OWNER", OWNER, 1);
    chk("rst_ERR", ERR_ORPHAN, 0);
    chk("rst_ADC_C", {ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP}, 0);
    chk("rst_REQ_C_Ready", REQ_C_Ready, 0);
    chk("rst_REQ_R_Valid", REQ_R_Valid, 0);

    // A: single 2-beat packet from req0, then its two responses
    acc_log.delete();
    add_pkt(0, 2, 1);
    wait_idle(50, "A");
    chk("A_acc_n", acc_log.size(), 2);
    if (acc_log.size() >= 2) begin
      eb = acc_log[0];
      chk("A_beat0", eb, {5'd1, 1'b1, 1'b0});
      eb = acc_log[1];
      chk("A_beat1", eb, {5'd2, 1'b0, 1'b1});
    end
    resp_mode = 1; p_resp = 100;
    wait_drain(50, "A");
    chk("A_rsp_req0", rsp_cnt[0], 2);
    chk("A_rsp_req1", rsp_cnt[1], 0);

    // B: simultaneous single-beat packets from both requesters, 4x each
    do_reset(1);
    @(negedge CLK);
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      add_pkt(0, 1, 4 + k);
      add_pkt(1, 1, 20 + k);
    end
    resp_mode = 1; p_resp = 50;
    wait_idle(300, "B");
    chk("B_grants_n", grant_log.size(), 8);
    if (grant_log.size() >= 4)
      for (int k = 0; k < 4; k++) chk("B_grant_order", grant_log[k], exp_g[k]);
    p_resp = 100;
    wait_drain(100, "B");

    // C: req1 six single-beat packets with no responses: stall at FIFO full
    do_reset(1);
    @(negedge CLK);
    resp_mode = 0;
    acc_cnt = 0;
    for (int k = 0; k < 6; k++) add_pkt(1, 1, 10 + k);
    repeat (20) @(negedge CLK);
    #3;
    chk("C_acc_at_full", acc_cnt, TAG_DEPTH);
    chk("C_left", src_q[1].size(), 6 - TAG_DEPTH);
    chk("C_ADC_C_Valid", ADC_C_Valid, 0);
    chk("C_REQ_C_Ready", REQ_C_Ready, 0);
    resp_mode = 1; p_resp = 100;
    wait_idle(200, "C");
    chk("C_acc_total", acc_cnt, 6);
    wait_drain(100, "C");

    // D: orphan response with empty FIFO, flag sticks through more traffic
    pulse_resp();
    @(negedge CLK);
    #3;
    chk("D_err_set", ERR_ORPHAN, 1);
    add_pkt(0, 2, 3);
    resp_mode = 1; p_resp = 100;
    wait_idle(50, "D");
    wait_drain(50, "D");
    chk("D_err_held", ERR_ORPHAN, 1);

    // E: owner stalls mid-packet while req1 waits, then reset mid-packet
    resp_mode = 0;
    add_pkt(0, 3, 5);
    n = 0;
    while (src_q[0].size() > 2 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("E_start_timeout", (n >= 50), 0);
    #3;
    stall[0] = 8;
    add_pkt(1, 1, 9);
    repeat (5) begin
      @(negedge CLK);
      #3;
      chk("E_lock_held", {BUSY, OWNER}, 2'b10);
      chk("E_req1_ready", REQ_C_Ready[1], 0);
      chk("E_adc_valid", ADC_C_Valid, 0);
    end
    do_reset(1);
    @(negedge CLK);
    #3;
    chk("E_rst_BUSY", BUSY, 0);
    chk("E_rst_ADC_C_Valid", ADC_C_Valid, 0);
    chk("E_rst_ERR", ERR_ORPHAN, 0);
    pulse_resp();
    @(negedge CLK);
    #3;
    chk("E_prereset_orphan", ERR_ORPHAN, 1);

    // F: randomised soak
    do_reset(2);
    @(negedge CLK);
    for (int k = 0; k < 15; k++) begin
      add_pkt(0, $urandom_range(1, 4), $urandom_range(0, 27));
      add_pkt(1, $urandom_range(1, 4), $urandom_range(0, 27));
    end
    p_valid = 70; p_rdy = 70; p_resp = 40; resp_mode = 1;
    wait_idle(5000, "F");
    p_resp = 100;
    wait_drain(200, "F");
    chk("F_err_clear", ERR_ORPHAN, 0);

    repeat (5) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_cmd_arbiter.md
ADC_CMD_ARBITER -- requirements
Module: adc_cmd_arbiter

Interface
REQ-001 The module SHALL have parameter TAG_DEPTH, default 4, giving the depth of the response-routing tag FIFO (power of two, 2..16).
REQ-002 The module SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RESETn  input  1  reset, synchronous, active-low.
REQ-004 The module SHALL have port REQ_C_Valid  input  2  per-requester command valid; bit i belongs to requester i.
REQ-005 The module SHALL have port REQ_C_Channel  input  10  per-requester command channel; requester i uses bits [5i+4:5i].
REQ-006 The module SHALL have port REQ_C_SOP  input  2  per-requester start-of-packet.
REQ-007 The module SHALL have port REQ_C_EOP  input  2  per-requester end-of-packet.
REQ-008 The module SHALL have port REQ_C_Ready  output  2  per-requester command ready.
REQ-009 The module SHALL have port ADC_C_Valid / ADC_C_Channel / ADC_C_SOP / ADC_C_EOP  output  1/5/1/1  shared ADC command port.
REQ-010 The module SHALL have port ADC_C_Ready  input  1  ADC command ready.
REQ-011 The module SHALL have port ADC_R_Valid / ADC_R_Channel / ADC_R_Data / ADC_R_SOP / ADC_R_EOP  input  1/5/12/1/1  ADC response.
REQ-012 The module SHALL have port REQ_R_Valid  output  2  per-requester response valid.
REQ-013 The module SHALL have port REQ_R_Channel / REQ_R_Data / REQ_R_SOP / REQ_R_EOP  output  5/12/1/1  response fields broadcast to both requesters.
REQ-014 The module SHALL have port BUSY  output  1  packet lock held; OWNER  output  1  index of current or last owner; ERR_ORPHAN  output  1  sticky orphan-response flag.

Function
REQ-015 The controller SHALL have two states: IDLE (no lock) and LOCK (packet owned by OWNER).
REQ-016 In IDLE, requester i is a candidate when REQ_C_Valid[i] & REQ_C_SOP[i]; Valid without SOP is ignored with REQ_C_Ready[i]=0.
REQ-017 In IDLE with at least one candidate and tag FIFO not full, the arbiter SHALL register the winner into OWNER and enter LOCK on the next edge (grant latency 1 cycle).
REQ-018 In IDLE, ADC_C_Valid and REQ_C_Ready SHALL be 0.
REQ-019 In LOCK, ADC_C_Valid/Channel/SOP/EOP SHALL combinationally equal the owner's command fields, REQ_C_Ready[OWNER]=ADC_C_Ready, and REQ_C_Ready of the other requester SHALL be 0.
REQ-020 In LOCK with tag FIFO full, ADC_C_Valid and REQ_C_Ready[OWNER] SHALL be forced 0, even if a pop occurs in the same cycle.
REQ-021 Each accepted beat (ADC_C_Valid & ADC_C_Ready) SHALL push OWNER into the tag FIFO.
REQ-022 An accepted beat with EOP=1 SHALL return the state to IDLE on the next edge; arbitration for the next packet starts in that IDLE cycle.
REQ-023 An owner deasserting Valid mid-packet SHALL NOT release the lock; there is no timeout.
REQ-024 Each ADC_R_Valid with tag FIFO non-empty SHALL pop the FIFO and assert REQ_R_Valid[head tag] in the same cycle (0-cycle latency); the other REQ_R_Valid bit SHALL be 0.
REQ-025 Each ADC_R_Valid with tag FIFO empty SHALL be dropped (REQ_R_Valid=00) and SHALL set ERR_ORPHAN, which stays set until reset.
REQ-026 Simultaneous push and pop when the FIFO is neither full nor empty SHALL both take effect, leaving the count unchanged.
REQ-027 FIFO read/write pointers SHALL wrap modulo TAG_DEPTH; occupancy count SHALL range 0..TAG_DEPTH.
REQ-028 BUSY SHALL be 1 exactly when the state is LOCK.

Reset
REQ-029 While RESETn=0 on a rising edge: state IDLE, FIFO empty (pointers and count 0), OWNER=1, ERR_ORPHAN=0, round-robin last-grant=1.
REQ-030 Reset mid-packet SHALL abandon the packet; responses arriving afterwards for pre-reset commands SHALL be treated as orphans.
REQ-031 After reset, all outputs SHALL be 0 except OWNER=1 and the broadcast response fields, which follow ADC_R_*.

Configuration
REQ-032 With macro ADC_ARB_ROUND_ROBIN_EN defined, ties SHALL go to the requester not granted last; last-grant updates on every grant.
REQ-033 Without ADC_ARB_ROUND_ROBIN_EN, ties SHALL always go to requester 0 (fixed priority), and the last-grant register SHALL be absent.

Verification
REQ-034 Req0 sends 2-beat packet ch 1,2 with ADC_C_Ready=1 -> grant 1 cycle after SOP, ADC sees ch1 SOP then ch2 EOP, two responses route to REQ_R_Valid=01.
REQ-035 Both requesters assert SOP in the same cycle after reset, 1-beat packets, repeated 4x -> with RR macro grants 0,1,0,1; without it grants 0,0,0,0 while req0 keeps requesting.
REQ-036 Req1 issues 6 single-beat packets with ADC_R_Valid held 0, TAG_DEPTH=4 -> after 4 accepted beats ADC_C_Valid=0 and REQ_C_Ready=00 until one response pops.
REQ-037 ADC_R_Valid pulse with FIFO empty -> REQ_R_Valid=00, ERR_ORPHAN=1 next cycle and held through further traffic.
REQ-038 Req0 mid 3-beat packet drops Valid 5 cycles while req1 requests -> lock holds, req1 Ready=0; RESETn=0 one cycle mid-packet -> IDLE, BUSY=0, FIFO count 0.
